// File: rtl/tod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tod_counter
// Purpose  : GMT time-of-day counter with settable time, hold (edit) mode,
//            time-zone offset and 12/24-hour local display.
//            Optional alarm compiled in with `define TOD_COUNTER_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tod_counter #(
  parameter int TICK_DIV   = 50000000,  // CLK cycles per second, >= 2
  parameter int RESET_HOUR = 15         // GMT hour loaded on reset, 0..23
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        SET_VALID,
  output logic        SET_READY,
  input  logic [17:0] SET_DATA,
  output logic        SET_ERR,
  input  logic        HOLD,
  input  logic [4:0]  TZ_OFFSET,
  input  logic        MODE_12H,
  output logic [17:0] GMT_DATA,
  output logic [17:0] DATA,
  output logic        PM,
  output logic        SEC_TICK
`ifdef TOD_COUNTER_ALARM_EN
  ,
  input  logic        ALARM_SET,
  input  logic [11:0] ALARM_TIME,
  input  logic        ALARM_ACK,
  output logic        ALARM
`endif
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                 c_pre_w      = $clog2(TICK_DIV);
  localparam logic [c_pre_w-1:0] c_pre_max    = c_pre_w'(TICK_DIV - 1);
  localparam logic [4:0]         c_reset_hour = 5'(RESET_HOUR);

  // --------------------------------------------------------------------------
  // Local hour from a GMT hour and a raw signed offset. The offset is clamped
  // to -12..+14 before the add so out-of-range codes behave like the limit.
  // --------------------------------------------------------------------------
  function automatic logic [4:0] f_local_hour(input logic [4:0] hour,
                                              input logic [4:0] tz);
    logic signed [4:0] tz_c;
    logic signed [6:0] sum;
    logic [4:0]        res;
    tz_c = $signed(tz);
    if (tz_c < -5'sd12) begin
      tz_c = -5'sd12;
    end else if (tz_c > 5'sd14) begin
      tz_c = 5'sd14;
    end
    sum = $signed({2'b00, hour}) + $signed({{2{tz_c[4]}}, tz_c});
    // Sum spans -12..37, so a single +/-24 correction lands in 0..23.
    if (sum < 7'sd0) begin
      sum = sum + 7'sd24;
    end else if (sum >= 7'sd24) begin
      sum = sum - 7'sd24;
    end
    res = sum[4:0];
    return res;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_pre_w-1:0] pre_q,      pre_d;
  logic [4:0]         hour_q,     hour_d;
  logic [5:0]         min_q,      min_d;
  logic [5:0]         sec_q,      sec_d;
  logic               set_err_q,  set_err_d;
  logic               sec_tick_q, sec_tick_d;
  logic [17:0]        data_q,     data_d;
  logic               pm_q,       pm_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic       w_tick;
  logic       w_set_ok;
  logic       w_set_load;
  logic       w_set_bad;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic [4:0] w_nxt_hour;
  logic [5:0] w_nxt_min;
  logic [5:0] w_nxt_sec;
  logic [4:0] w_local_hour;
  logic [4:0] w_disp_hour;

  // The handshake is always ready: a request is consumed in the cycle it is seen.
  assign SET_READY = SET_VALID;

  // Decode the second increment and the validity of a set request.
  always_comb begin
    w_tick     = (pre_q == c_pre_max) && !HOLD;
    w_set_ok   = (SET_DATA[17:12] <= 6'd23) &&
                 (SET_DATA[11:6]  <= 6'd59) &&
                 (SET_DATA[5:0]   <= 6'd59);
    w_set_load = SET_VALID && w_set_ok;
    w_set_bad  = SET_VALID && !w_set_ok;
  end

  // Time one second ahead of the current GMT time, with full carry chain.
  always_comb begin
    w_sec_wrap = (sec_q == 6'd59);
    w_min_wrap = (min_q == 6'd59);
    w_nxt_sec  = w_sec_wrap ? 6'd0 : sec_q + 6'd1;
    w_nxt_min  = min_q;
    w_nxt_hour = hour_q;
    if (w_sec_wrap) begin
      w_nxt_min = w_min_wrap ? 6'd0 : min_q + 6'd1;
      if (w_min_wrap) begin
        w_nxt_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      end
    end
  end

  // Next GMT state: a valid set overrides counting; otherwise run the prescaler.
  always_comb begin
    pre_d      = pre_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    set_err_d  = w_set_bad;
    if (w_set_load) begin
      hour_d = SET_DATA[16:12];
      min_d  = SET_DATA[11:6];
      sec_d  = SET_DATA[5:0];
      pre_d  = '0;
    end else if (!HOLD) begin
      if (w_tick) begin
        pre_d      = '0;
        hour_d     = w_nxt_hour;
        min_d      = w_nxt_min;
        sec_d      = w_nxt_sec;
        sec_tick_d = 1'b1;
      end else begin
        pre_d = pre_q + c_pre_w'(1);
      end
    end
  end

  // Local display time derived from the current GMT time and display inputs.
  always_comb begin
    w_local_hour = f_local_hour(hour_q, TZ_OFFSET);
    w_disp_hour  = w_local_hour;
    if (MODE_12H) begin
      if (w_local_hour == 5'd0) begin
        w_disp_hour = 5'd12;
      end else if (w_local_hour >= 5'd13) begin
        w_disp_hour = w_local_hour - 5'd12;
      end
    end
    pm_d   = (w_local_hour >= 5'd12);
    data_d = {1'b0, w_disp_hour, min_q, sec_q};
  end

  // GMT time, prescaler and status pulse registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pre_q      <= '0;
      hour_q     <= c_reset_hour;
      min_q      <= 6'd0;
      sec_q      <= 6'd0;
      set_err_q  <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      set_err_q  <= set_err_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  // Display registers lag GMT by one cycle and stay zero while in reset.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      data_q <= 18'd0;
      pm_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      pm_q   <= pm_d;
    end
  end

  assign GMT_DATA = {1'b0, hour_q, min_q, sec_q};
  assign DATA     = data_q;
  assign PM       = pm_q;
  assign SET_ERR  = set_err_q;
  assign SEC_TICK = sec_tick_q;

`ifdef TOD_COUNTER_ALARM_EN
  // --------------------------------------------------------------------------
  // Alarm: fires on a counting increment that lands on local hh:mm:00.
  // Set loads never fire it; an acknowledge beats a coincident match.
  // --------------------------------------------------------------------------
  logic alarm_q, alarm_d;
  logic w_alarm_hit;

  // Match the upcoming local time against the programmed alarm time.
  always_comb begin
    w_alarm_hit = w_tick && !w_set_load && ALARM_SET &&
                  (w_nxt_sec == 6'd0) &&
                  (w_nxt_min == ALARM_TIME[5:0]) &&
                  ({1'b0, f_local_hour(w_nxt_hour, TZ_OFFSET)} == ALARM_TIME[11:6]);
    alarm_d = alarm_q;
    if (ALARM_ACK) begin
      alarm_d = 1'b0;
    end else if (w_alarm_hit) begin
      alarm_d = 1'b1;
    end
  end

  // Sticky alarm flag.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end

  assign ALARM = alarm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tod_counter
// Purpose  : Self-checking bench for tod_counter (TICK_DIV=4): directed
//            table, hand sequences for multi-cycle corners, and a random run
//            against a seconds-of-day reference model.
//            Alarm checks are built when TOD_COUNTER_ALARM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tod_counter;

  localparam int TICK_DIV   = 4;
  localparam int RESET_HOUR = 15;

  logic        clk = 1'b0;
  logic        rstn;
  logic        set_valid;
  logic        set_ready;
  logic [17:0] set_data;
  logic        set_err;
  logic        hold;
  logic [4:0]  tz;
  logic        mode12;
  logic [17:0] gmt_data;
  logic [17:0] data;
  logic        pm;
  logic        sec_tick;
`ifdef TOD_COUNTER_ALARM_EN
  logic        alarm_set;
  logic [11:0] alarm_time;
  logic        alarm_ack;
  logic        alarm;
`endif

  tod_counter #(.TICK_DIV(TICK_DIV), .RESET_HOUR(RESET_HOUR)) dut (
    .CLK       (clk),
    .RESETN    (rstn),
    .SET_VALID (set_valid),
    .SET_READY (set_ready),
    .SET_DATA  (set_data),
    .SET_ERR   (set_err),
    .HOLD      (hold),
    .TZ_OFFSET (tz),
    .MODE_12H  (mode12),
    .GMT_DATA  (gmt_data),
    .DATA      (data),
    .PM        (pm),
    .SEC_TICK  (sec_tick)
`ifdef TOD_COUNTER_ALARM_EN
    ,
    .ALARM_SET (alarm_set),
    .ALARM_TIME(alarm_time),
    .ALARM_ACK (alarm_ack),
    .ALARM     (alarm)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] hms(input int h, input int m, input int s);
    return {6'(h), 6'(m), 6'(s)};
  endfunction

  // ---------------------------------------------------------------- model
  int          m_secs;
  int          m_pre;
  bit          m_tick;
  bit          m_err;
  logic [17:0] m_data;
  bit          m_pm;

  function automatic logic [17:0] gmt_of(input int secs);
    return hms(secs / 3600, (secs / 60) % 60, secs % 60);
  endfunction

  task automatic calc_disp(input int secs, input logic [4:0] tzv, input bit md,
                           output logic [17:0] d, output bit p);
    int tzi;
    int lh;
    int dh;
    tzi = int'($signed(tzv));
    if (tzi < -12) tzi = -12;
    if (tzi > 14)  tzi = 14;
    lh = (secs / 3600 + tzi + 24) % 24;
    p  = (lh >= 12);
    dh = md ? ((lh % 12 == 0) ? 12 : lh % 12) : lh;
    d  = hms(dh, (secs / 60) % 60, secs % 60);
  endtask

  task automatic model_reset();
    m_secs = RESET_HOUR * 3600;
    m_pre  = 0;
    m_tick = 0;
    m_err  = 0;
    m_data = '0;
    m_pm   = 0;
  endtask

  // Effect of one rising edge with the inputs currently applied.
  task automatic model_edge();
    logic [17:0] nd;
    bit          np;
    int          h, mi, s;
    calc_disp(m_secs, tz, mode12, nd, np);
    m_data = nd;
    m_pm   = np;
    m_tick = 0;
    m_err  = 0;
    h  = int'(set_data[17:12]);
    mi = int'(set_data[11:6]);
    s  = int'(set_data[5:0]);
    if (set_valid && h <= 23 && mi <= 59 && s <= 59) begin
      m_secs = h * 3600 + mi * 60 + s;
      m_pre  = 0;
    end else begin
      m_err = set_valid;
      if (!hold) begin
        if (m_pre == TICK_DIV - 1) begin
          m_pre  = 0;
          m_secs = (m_secs + 1) % 86400;
          m_tick = 1;
        end else begin
          m_pre++;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------- table
  typedef struct {
    logic [17:0] set;
    logic [4:0]  tzv;
    bit          md;
    logic [17:0] exp_data;
    bit          exp_pm;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tick_at;
    int ticks;

    vecs[0]  = '{hms(3, 0, 0),    5'b11011, 1'b0, hms(22, 0, 0),   1'b1};
    vecs[1]  = '{hms(3, 0, 0),    5'b11011, 1'b1, hms(10, 0, 0),   1'b1};
    vecs[2]  = '{hms(12, 0, 0),   5'b00000, 1'b1, hms(12, 0, 0),   1'b1};
    vecs[3]  = '{hms(0, 30, 0),   5'b00000, 1'b1, hms(12, 30, 0),  1'b0};
    vecs[4]  = '{hms(13, 15, 20), 5'b00000, 1'b1, hms(1, 15, 20),  1'b1};
    vecs[5]  = '{hms(10, 0, 0),   5'b01111, 1'b0, hms(0, 0, 0),    1'b0};
    vecs[6]  = '{hms(10, 0, 0),   5'b10000, 1'b0, hms(22, 0, 0),   1'b1};
    vecs[7]  = '{hms(5, 6, 7),    5'b01110, 1'b1, hms(7, 6, 7),    1'b1};
    vecs[8]  = '{hms(11, 0, 0),   5'b00001, 1'b1, hms(12, 0, 0),   1'b1};
    vecs[9]  = '{hms(23, 59, 59), 5'b01001, 1'b0, hms(8, 59, 59),  1'b0};
    vecs[10] = '{hms(0, 0, 0),    5'b10100, 1'b0, hms(12, 0, 0),   1'b1};
    vecs[11] = '{hms(23, 45, 1),  5'b00000, 1'b1, hms(11, 45, 1),  1'b1};

    rstn = 1'b0; set_valid = 1'b0; set_data = '0; hold = 1'b0; tz = '0; mode12 = 1'b0;
`ifdef TOD_COUNTER_ALARM_EN
    alarm_set = 1'b0; alarm_time = '0; alarm_ack = 1'b0;
`endif

    // ---- reset state and first second after release
    repeat (3) step();
    chk("rst_gmt",   32'(gmt_data), 32'(hms(15, 0, 0)));
    chk("rst_data",  32'(data),     32'd0);
    chk("rst_pm",    32'(pm),       32'd0);
    chk("rst_tick",  32'(sec_tick), 32'd0);
    chk("rst_err",   32'(set_err),  32'd0);
    rstn = 1'b1;
    tick_at = 0;
    for (int k = 1; k <= 8 && tick_at == 0; k++) begin
      step();
      if (k == 1) begin
        chk("post_rst_data", 32'(data), 32'(hms(15, 0, 0)));
        chk("post_rst_pm",   32'(pm),   32'd1);
      end
      if (sec_tick) tick_at = k;
    end
    chk("first_tick_cycle", 32'(tick_at),  32'd4);
    chk("first_tick_gmt",   32'(gmt_data), 32'(hms(15, 0, 1)));

    // ---- directed display table (counting frozen)
    hold = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_valid = 1'b1; set_data = vecs[i].set; tz = vecs[i].tzv; mode12 = vecs[i].md;
      step();
      set_valid = 1'b0;
      chk($sformatf("tbl%0d_gmt", i), 32'(gmt_data), 32'(vecs[i].set));
      step();
      chk($sformatf("tbl%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
      chk($sformatf("tbl%0d_pm", i),   32'(pm),   32'(vecs[i].exp_pm));
    end

    // ---- day wrap then +9 offset
    hold = 1'b0; mode12 = 1'b0; tz = 5'd9;
    set_valid = 1'b1; set_data = hms(23, 59, 59);
    step();
    set_valid = 1'b0;
    repeat (4) step();
    chk("wrap_tick", 32'(sec_tick), 32'd1);
    chk("wrap_gmt",  32'(gmt_data), 32'(hms(0, 0, 0)));
    step();
    chk("wrap_data", 32'(data), 32'(hms(9, 0, 0)));
    chk("wrap_pm",   32'(pm),   32'd0);

    // ---- out-of-range sets
    hold = 1'b1;
    set_valid = 1'b1; set_data = hms(10, 20, 30);
    step();
    set_data = hms(24, 0, 0);
    #1;
    chk("ready_comb", 32'(set_ready), 32'd1);
    step();
    set_valid = 1'b0;
    chk("bad_hour_err", 32'(set_err),  32'd1);
    chk("bad_hour_gmt", 32'(gmt_data), 32'(hms(10, 20, 30)));
    step();
    chk("bad_hour_err_clr", 32'(set_err), 32'd0);
    set_valid = 1'b1; set_data = hms(10, 60, 0);
    step();
    set_valid = 1'b0;
    chk("bad_min_err", 32'(set_err),  32'd1);
    chk("bad_min_gmt", 32'(gmt_data), 32'(hms(10, 20, 30)));
    step();
    chk("ready_idle", 32'(set_ready), 32'd0);

    // ---- hold for 10 seconds' worth of cycles
    ticks = 0;
    for (int k = 0; k < 10 * TICK_DIV; k++) begin
      step();
      if (sec_tick) ticks++;
    end
    chk("hold_ticks", 32'(ticks),    32'd0);
    chk("hold_gmt",   32'(gmt_data), 32'(hms(10, 20, 30)));

    // ---- prescaler resumes from frozen value
    hold = 1'b0;
    set_valid = 1'b1; set_data = hms(1, 0, 0);
    step();
    set_valid = 1'b0;
    repeat (2) step();
    hold = 1'b1;
    repeat (10) step();
    hold = 1'b0;
    step();
    chk("resume_no_tick", 32'(sec_tick), 32'd0);
    step();
    chk("resume_tick", 32'(sec_tick), 32'd1);
    chk("resume_gmt",  32'(gmt_data), 32'(hms(1, 0, 1)));

    // ---- set coincident with a tick wins and restarts the prescaler
    repeat (3) step();
    set_valid = 1'b1; set_data = hms(5, 6, 7);
    step();
    set_valid = 1'b0;
    chk("coinc_gmt",  32'(gmt_data), 32'(hms(5, 6, 7)));
    chk("coinc_tick", 32'(sec_tick), 32'd0);
    tick_at = 0;
    for (int k = 1; k <= 8 && tick_at == 0; k++) begin
      step();
      if (sec_tick) tick_at = k;
    end
    chk("coinc_next_tick", 32'(tick_at),  32'd4);
    chk("coinc_next_gmt",  32'(gmt_data), 32'(hms(5, 6, 8)));

`ifdef TOD_COUNTER_ALARM_EN
    // ---- alarm on entering 07:30:00 local
    tz = 5'd0; alarm_set = 1'b1; alarm_time = {6'd7, 6'd30};
    set_valid = 1'b1; set_data = hms(7, 29, 59);
    step();
    set_valid = 1'b0;
    chk("alarm_pre", 32'(alarm), 32'd0);
    tick_at = 0;
    for (int k = 1; k <= 8 && tick_at == 0; k++) begin
      step();
      if (alarm) tick_at = k;
    end
    chk("alarm_cycle", 32'(tick_at),  32'd4);
    chk("alarm_gmt",   32'(gmt_data), 32'(hms(7, 30, 0)));
    step();
    chk("alarm_sticky", 32'(alarm), 32'd1);
    alarm_ack = 1'b1;
    step();
    alarm_ack = 1'b0; alarm_set = 1'b0;
    chk("alarm_ack", 32'(alarm), 32'd0);
`endif

    // ---- reset in the middle of a bad set request
    set_valid = 1'b1; set_data = hms(30, 0, 0); rstn = 1'b0;
    step();
    chk("midrst_err", 32'(set_err),  32'd0);
    chk("midrst_gmt", 32'(gmt_data), 32'(hms(15, 0, 0)));
    set_valid = 1'b0;
    step();

    // ---- random run against the reference model
    rstn = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      set_valid = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 3))
        0:       set_data = 18'($urandom);
        1:       set_data = hms(23, 59, int'($urandom_range(55, 59)));
        default: set_data = hms(int'($urandom_range(0, 25)), int'($urandom_range(0, 61)),
                                int'($urandom_range(0, 61)));
      endcase
      hold   = ($urandom_range(0, 3) == 0);
      tz     = 5'($urandom);
      mode12 = 1'($urandom);
      #1;
      chk("rnd_ready", 32'(set_ready), 32'(set_valid));
      model_edge();
      step();
      chk("rnd_gmt",  32'(gmt_data),
          32'(gmt_of(m_secs)));
      chk("rnd_disp", {12'd0, data, pm, sec_tick, set_err},
          {12'd0, m_data, m_pm, m_tick, m_err});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
